controle_rodadas: RTL

- Turn-sequencing control unit for the ultimate tic-tac-toe game (jogao_da_velha).
- Sits between the button inputs and the board datapath. It captures one-hot button presses and sequences macro and micro selection, cell writes, macro-board closing and player alternation.
- It also enforces the next-macro rule and an inactivity timeout, and reports game end.
- The datapath holds board storage and win/full detection. This block only issues selects and write strobes.

---
 rtl/jogo_pkg.sv | 49 ++++
 rtl/detector_jogada.sv | 43 ++++
 rtl/controle_rodadas.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared types for the ultimate tic-tac-toe turn controller: state codes,
// winner codes and the one-hot button decoder.
package jogo_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    ESPERA_MACRO   = 4'd2,
    REGISTRA_MACRO = 4'd3,
    ESPERA_MICRO   = 4'd4,
    REGISTRA_MICRO = 4'd5,
    AVALIA         = 4'd6,
    FECHA_MACRO    = 4'd7,
    CHECA_FIM      = 4'd8,
    TROCA_JOGADOR  = 4'd9,
    EXIBE          = 4'd10,
    FIM            = 4'd11
  } estado_t;

  localparam logic [1:0] GAN_NENHUM = 2'b00;
  localparam logic [1:0] GAN_J1     = 2'b01;
  localparam logic [1:0] GAN_J2     = 2'b10;
  localparam logic [1:0] GAN_EMPATE = 2'b11;

  typedef struct packed {
    logic             valido;
    logic [IDX_W-1:0] idx;
  } indice_t;

  // valido only when exactly one of the nine bits is set
  function automatic indice_t onehot_para_indice(input logic [8:0] v);
    indice_t    r;
    logic [3:0] n;
    r.valido = 1'b0;
    r.idx    = '0;
    n        = '0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) begin
        n     = n + 4'd1;
        r.idx = IDX_W'(i);
      end
    end
    r.valido = (n == 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/detector_jogada.sv
// Button front end: two-flop synchronizer, previous-value flop and a
// one-hot check so that each clean press yields exactly one evento.
module detector_jogada
  import jogo_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [8:0]       botoes,
  output logic             evento,
  output logic [IDX_W-1:0] idx
);

  logic [8:0] sync1_q, sync1_d;
  logic [8:0] sync2_q, sync2_d;
  logic [8:0] prev_q,  prev_d;
  indice_t    dec;

  always_comb begin
    sync1_d = botoes;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // prev must be all-zero so a held button or a partial release never re-fires
  always_comb begin
    dec    = onehot_para_indice(sync2_q);
    evento = dec.valido && (prev_q == '0);
    idx    = dec.idx;
  end

endmodule

// File: rtl/controle_rodadas.sv
// Turn sequencer for ultimate tic-tac-toe: macro/micro selection, write and
// close strobes, player alternation, next-macro rule and inactivity forfeit.
module controle_rodadas
  import jogo_pkg::*;
#(
  parameter int ESPERA_CICLOS  = 100,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [8:0] botoes,
  input  logic [8:0] micro_ocupado,
  input  logic [8:0] macro_fechado,
  input  logic       vitoria_micro,
  input  logic       micro_cheio,
  input  logic       vitoria_macro,
  input  logic       macro_empate,
  output logic [3:0] macro_sel,
  output logic [3:0] micro_sel,
  output logic       jogador,
  output logic       zera_tabuleiro,
  output logic       escreve_micro,
  output logic       fecha_macro,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       pronto,
  output logic [1:0] ganhador,
  output logic [3:0] db_estado
);

  localparam int MAX_CICLOS = (ESPERA_CICLOS > TIMEOUT_CICLOS) ? ESPERA_CICLOS : TIMEOUT_CICLOS;
  localparam int CNT_W      = $clog2(MAX_CICLOS + 1);

  logic             evento;
  logic [IDX_W-1:0] idx;

  detector_jogada u_detector (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .evento (evento),
    .idx    (idx)
  );

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       macro_sel_q, macro_sel_d;
  logic [3:0]       micro_sel_q, micro_sel_d;
  logic             jogador_q, jogador_d;
  logic [1:0]       ganhador_q, ganhador_d;
  logic             zera_q, zera_d;
  logic             escreve_q, escreve_d;
  logic             fecha_q, fecha_d;
  logic             jogar_macro_q, jogar_macro_d;
  logic             jogar_micro_q, jogar_micro_d;
  logic             pronto_q, pronto_d;
  logic             fim_espera, estouro, conta;

  always_comb begin
    estado_d    = estado_q;
    macro_sel_d = macro_sel_q;
    micro_sel_d = micro_sel_q;
    jogador_d   = jogador_q;
    ganhador_d  = ganhador_q;
    fim_espera  = (cnt_q == CNT_W'(ESPERA_CICLOS - 1));
    estouro     = (cnt_q == CNT_W'(TIMEOUT_CICLOS - 1));

    case (estado_q)
      INICIAL: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        jogador_d   = 1'b0;
        ganhador_d  = GAN_NENHUM;
        macro_sel_d = '0;
        estado_d    = ESPERA_MACRO;
      end
      // an accepted press takes priority over a timeout in the same cycle
      ESPERA_MACRO: begin
        if (evento && !macro_fechado[idx]) begin
          macro_sel_d = idx;
          estado_d    = REGISTRA_MACRO;
        end else if (estouro) begin
          ganhador_d = jogador_q ? GAN_J1 : GAN_J2;
          estado_d   = FIM;
        end
      end
      REGISTRA_MACRO: estado_d = ESPERA_MICRO;
      ESPERA_MICRO: begin
        if (evento && !micro_ocupado[idx]) begin
          micro_sel_d = idx;
          estado_d    = REGISTRA_MICRO;
        end else if (estouro) begin
          ganhador_d = jogador_q ? GAN_J1 : GAN_J2;
          estado_d   = FIM;
        end
      end
      REGISTRA_MICRO: estado_d = AVALIA;
      AVALIA: estado_d = (vitoria_micro || micro_cheio) ? FECHA_MACRO : TROCA_JOGADOR;
      FECHA_MACRO: estado_d = CHECA_FIM;
      CHECA_FIM: begin
        if (vitoria_macro) begin
          ganhador_d = jogador_q ? GAN_J2 : GAN_J1;
          estado_d   = FIM;
        end else if (macro_empate) begin
          ganhador_d = GAN_EMPATE;
          estado_d   = FIM;
        end else begin
          estado_d = TROCA_JOGADOR;
        end
      end
      // the cell just played names the macro the opponent must play in
      TROCA_JOGADOR: begin
        jogador_d   = ~jogador_q;
        macro_sel_d = micro_sel_q;
        estado_d    = EXIBE;
      end
      EXIBE: begin
        if (fim_espera) estado_d = macro_fechado[macro_sel_q] ? ESPERA_MACRO : ESPERA_MICRO;
      end
      FIM: if (iniciar) estado_d = PREPARA;
      default: estado_d = INICIAL;
    endcase

    conta = (estado_q == ESPERA_MACRO) || (estado_q == ESPERA_MICRO) || (estado_q == EXIBE);
    if ((estado_d != estado_q) || !conta) cnt_d = '0;
    else                                  cnt_d = cnt_q + 1'b1;

    // Moore outputs are decoded from the next state so they register in step with it
    zera_d        = (estado_d == PREPARA);
    escreve_d     = (estado_d == REGISTRA_MICRO);
    fecha_d       = (estado_d == FECHA_MACRO);
    jogar_macro_d = (estado_d == ESPERA_MACRO);
    jogar_micro_d = (estado_d == ESPERA_MICRO);
    pronto_d      = (estado_d == FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= INICIAL;
      cnt_q         <= '0;
      macro_sel_q   <= '0;
      micro_sel_q   <= '0;
      jogador_q     <= 1'b0;
      ganhador_q    <= GAN_NENHUM;
      zera_q        <= 1'b0;
      escreve_q     <= 1'b0;
      fecha_q       <= 1'b0;
      jogar_macro_q <= 1'b0;
      jogar_micro_q <= 1'b0;
      pronto_q      <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      cnt_q         <= cnt_d;
      macro_sel_q   <= macro_sel_d;
      micro_sel_q   <= micro_sel_d;
      jogador_q     <= jogador_d;
      ganhador_q    <= ganhador_d;
      zera_q        <= zera_d;
      escreve_q     <= escreve_d;
      fecha_q       <= fecha_d;
      jogar_macro_q <= jogar_macro_d;
      jogar_micro_q <= jogar_micro_d;
      pronto_q      <= pronto_d;
    end
  end

  assign macro_sel      = macro_sel_q;
  assign micro_sel      = micro_sel_q;
  assign jogador        = jogador_q;
  assign ganhador       = ganhador_q;
  assign zera_tabuleiro = zera_q;
  assign escreve_micro  = escreve_q;
  assign fecha_macro    = fecha_q;
  assign jogar_macro    = jogar_macro_q;
  assign jogar_micro    = jogar_micro_q;
  assign pronto         = pronto_q;
  assign db_estado      = estado_q;

endmodule
